fifo_replay_ctrl: RTL and testbench

- Control stage directly upstream of the activation/weight FIFO in the systolic datapath. Drives its wr_clr/wr_en/wr_inc and rd_clr/rd_en/rd_inc pins.
- Per job: fills the FIFO with cfg_len words from an in_valid/in_ready stream, waits cfg_skew cycles (systolic row skew), then replays the stored words cfg_repeat times.
- Emits out_valid/out_last aligned with the FIFO's 1-cycle read data.

---
 rtl/fifo_replay_ctrl.sv | 140 ++++++++++++++
 tb/tb_fifo_replay_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fifo_replay_ctrl.sv
// fifo_replay_ctrl: fills a FIFO with cfg_len words, waits cfg_skew cycles, then replays them cfg_repeat times.
// Optional READ_THROTTLE_EN adds rd_pause to stall READ.
module fifo_replay_ctrl #(
  parameter int ADDR_WIDTH = 13,
  parameter int REP_WIDTH  = 8,
  parameter int SKEW_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] cfg_len,
  input  logic [REP_WIDTH-1:0]  cfg_repeat,
  input  logic [SKEW_WIDTH-1:0] cfg_skew,
  input  logic                  in_valid,
`ifdef READ_THROTTLE_EN
  input  logic                  rd_pause,
`endif
  output logic                  in_ready,
  output logic                  wr_clr,
  output logic                  wr_en,
  output logic                  wr_inc,
  output logic                  rd_clr,
  output logic                  rd_en,
  output logic                  rd_inc,
  output logic                  out_valid,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);
  typedef enum logic [2:0] {IDLE, CLEAR, FILL, SKEW, READ, REWIND, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d, wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic [REP_WIDTH-1:0]  rep_q, rep_d, pass_cnt_q, pass_cnt_d;
  logic [SKEW_WIDTH-1:0] skew_q, skew_d, skew_cnt_q, skew_cnt_d;
  logic out_valid_d, out_last_d, done_d, out_valid_q, out_last_q, done_q;
  logic pause, rd_last, pass_last;
`ifdef READ_THROTTLE_EN
  assign pause = rd_pause;
`else
  assign pause = 1'b0;
`endif
  assign rd_last   = rd_cnt_q == len_q - 1'b1;
  assign pass_last = pass_cnt_q == rep_q - 1'b1;
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    rep_d      = rep_q;
    skew_d     = skew_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    pass_cnt_d = pass_cnt_q;
    skew_cnt_d = skew_cnt_q;
    in_ready   = 1'b0;
    wr_clr     = 1'b0;
    wr_en      = 1'b0;
    wr_inc     = 1'b0;
    rd_clr     = 1'b0;
    rd_en      = 1'b0;
    rd_inc     = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        len_d   = cfg_len;
        rep_d   = cfg_repeat;
        skew_d  = cfg_skew;
        state_d = CLEAR;
      end
      CLEAR: begin
        wr_clr     = 1'b1;
        rd_clr     = 1'b1;
        wr_cnt_d   = '0;
        rd_cnt_d   = '0;
        pass_cnt_d = '0;
        skew_cnt_d = '0;
        state_d    = len_q == '0 ? DONE : FILL;
      end
      FILL: begin
        in_ready = 1'b1;
        wr_inc   = 1'b1;
        wr_en    = in_valid;
        if (in_valid) begin
          wr_cnt_d = wr_cnt_q + 1'b1;
          if (wr_cnt_q == len_q - 1'b1)
            state_d = rep_q == '0 ? DONE : skew_q != '0 ? SKEW : READ;
        end
      end
      SKEW: begin
        skew_cnt_d = skew_cnt_q + 1'b1;
        if (skew_cnt_q == skew_q - 1'b1) state_d = READ;
      end
      READ: if (!pause) begin
        rd_en    = 1'b1;
        rd_inc   = 1'b1;
        rd_cnt_d = rd_cnt_q + 1'b1;
        if (rd_last) state_d = pass_last ? DONE : REWIND;
      end
      REWIND: begin
        rd_clr     = 1'b1;
        rd_cnt_d   = '0;
        pass_cnt_d = pass_cnt_q + 1'b1;
        state_d    = READ;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    out_valid_d = rd_en;
    out_last_d  = rd_en && rd_last && pass_last;
    done_d      = state_d == DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      rep_q       <= '0;
      skew_q      <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      pass_cnt_q  <= '0;
      skew_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      rep_q       <= rep_d;
      skew_q      <= skew_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      pass_cnt_q  <= pass_cnt_d;
      skew_cnt_q  <= skew_cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign done      = done_q;
  assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_fifo_replay_ctrl.sv
// tb_fifo_replay_ctrl: random jobs against a FIFO model and a replay-order scoreboard.
module tb_fifo_replay_ctrl;
  localparam int AW = 13;
  localparam int RW = 8;
  localparam int SW = 5;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, rd_pause = 1'b0;
  logic [AW-1:0] cfg_len = '0;
  logic [RW-1:0] cfg_repeat = '0;
  logic [SW-1:0] cfg_skew = '0;
  logic [15:0] in_data = '0;
  logic in_ready, wr_clr, wr_en, wr_inc, rd_clr, rd_en, rd_inc, out_valid, out_last, busy, done;

  fifo_replay_ctrl #(.ADDR_WIDTH(AW), .REP_WIDTH(RW), .SKEW_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len), .cfg_repeat(cfg_repeat),
    .cfg_skew(cfg_skew), .in_valid(in_valid),
`ifdef READ_THROTTLE_EN
    .rd_pause(rd_pause),
`endif
    .in_ready(in_ready), .wr_clr(wr_clr), .wr_en(wr_en), .wr_inc(wr_inc), .rd_clr(rd_clr),
    .rd_en(rd_en), .rd_inc(rd_inc), .out_valid(out_valid), .out_last(out_last),
    .busy(busy), .done(done));

  always #5 clk = ~clk;

  typedef struct {logic [15:0] d; logic last;} exp_t;
  exp_t exp_q[$];
  exp_t e;
  int n_chk = 0, n_fail = 0;
  int cur_len = 0, cur_rep = 0, cur_skew = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Behavioural FIFO driven by the controller's pins; pointers survive rst_n like the real one.
  logic [15:0] mem [0:8191];
  logic [15:0] dout = '0;
  int wp = 0, rp = 0;
  always @(posedge clk) begin
    if (wr_clr) wp <= 0;
    else if (wr_en && wr_inc) begin
      mem[wp % 8192] <= in_data;
      wp <= wp + 1;
    end
    if (rd_clr) begin
      rp <= 0;
      dout <= '0;
    end else if (rd_en) begin
      dout <= mem[rp % 8192];
      if (rd_inc) rp <= rp + 1;
    end
  end

  int cyc = 0, nw = 0, nr = 0, nrc = 0, last_wr = 0, first_rd = -1;
  always begin
    @(negedge clk);
    #1;
    if (rst_n) begin
      cyc++;
      chk("wr_en_vs_handshake", wr_en, in_valid && in_ready);
      if (wr_clr) begin nw = 0; nr = 0; nrc = 0; first_rd = -1; last_wr = cyc; end
      if (wr_en) begin nw++; last_wr = cyc; end
      if (rd_en) begin nr++; if (first_rd < 0) first_rd = cyc; end
      if (rd_clr && !wr_clr) nrc++;
      if (out_valid) begin
        if (exp_q.size() == 0) chk("unexpected_out_valid", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("out_data", dout, e.d);
          chk("out_last", out_last, e.last);
        end
      end else chk("out_last_without_valid", out_last, 0);
      if (done) begin
        chk("pending_at_done", exp_q.size(), 0);
        chk("writes_per_job", nw, cur_len);
        chk("reads_per_job", nr, cur_len * cur_rep);
        chk("rewinds_per_job", nrc, cur_len * cur_rep > 0 ? cur_rep - 1 : 0);
        chk("out_last_with_done", out_last, cur_len * cur_rep > 0);
`ifndef READ_THROTTLE_EN
        if (cur_len * cur_rep > 0) chk("skew_gap", first_rd - last_wr, cur_skew + 1);
`endif
      end
    end
  end

`ifdef READ_THROTTLE_EN
  initial forever begin
    @(negedge clk);
    rd_pause = $urandom_range(3) == 0;
  end
`endif

  task automatic run_job(input int len, input int rep, input int skew, input int prob, input bit abort);
    logic [15:0] words[$];
    int idx, guard;
    bit acc, seen;
    cur_len = len; cur_rep = rep; cur_skew = skew;
    for (int i = 0; i < len; i++) words.push_back(16'($urandom));
    for (int p = 0; p < rep; p++)
      for (int i = 0; i < len; i++) exp_q.push_back('{words[i], p == rep - 1 && i == len - 1});
    @(negedge clk);
    start = 1'b1; cfg_len = AW'(len); cfg_repeat = RW'(rep); cfg_skew = SW'(skew);
    @(posedge clk);
    #1;
    start = 1'b0;
    cfg_len = AW'($urandom); cfg_repeat = RW'($urandom); cfg_skew = SW'($urandom);
    chk("clear_after_start", {wr_clr, rd_clr, wr_en, rd_en}, 4'b1100);
    idx = 0; guard = 0;
    while (idx < len && guard < 50 * len + 20) begin
      @(negedge clk);
      in_valid = $urandom_range(99) < 32'(prob);
      in_data = words[idx];
      #1;
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) idx++;
      guard++;
    end
    if (idx < len) chk("fill_timeout", idx, len);
    if (abort) begin
      seen = 0;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        if (rd_clr && !wr_clr) seen = 1;
        else if (seen && rd_en) break;
      end
      #1 rst_n = 1'b0;
      #1 chk("abort_outputs_zero", {in_ready, wr_clr, wr_en, wr_inc, rd_clr, rd_en, rd_inc,
                                    out_valid, out_last, busy, done}, 0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      return;
    end
    for (int c = 0; c <= 4 * len * rep + skew + 40; c++) begin
      @(negedge clk);
      in_valid = $urandom_range(1);
      in_data = 16'($urandom);
      #1;
      if (done) break;
    end
    chk("done_seen", done, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("busy_after_done", busy, 0);
  endtask

  initial begin
    #1 chk("reset_outputs_zero", {in_ready, wr_clr, wr_en, wr_inc, rd_clr, rd_en, rd_inc,
                                  out_valid, out_last, busy, done}, 0);
    #12 rst_n = 1'b1;
    run_job(4, 1, 0, 100, 0);
    run_job(3, 3, 2, 100, 0);
    run_job(4, 1, 0, 50, 0);
    run_job(0, 1, 3, 100, 0);
    run_job(2, 0, 1, 100, 0);
    run_job(4, 2, 0, 100, 1);
    run_job(4, 1, 0, 100, 0);
    for (int j = 0; j < 30; j++)
      run_job($urandom_range(12), $urandom_range(4), $urandom_range(6), $urandom_range(100, 30), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
